// File: rtl/duck_palette_arbiter.sv
// Round-robin arbiter sharing one combinational palette ROM among NREQ sprite layers.
// Optional feature macro SPRITE_PAL_CLAMP_EN clamps out-of-range indices to CLAMP_INDEX.
module duck_palette_arbiter #(
    parameter int unsigned NREQ              = 4,
    parameter int unsigned IDX_W             = 4,
    parameter int unsigned NUM_COLORS        = 5,
    parameter int unsigned CLAMP_INDEX       = 1,
    parameter int unsigned TRANSPARENT_INDEX = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_start,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*IDX_W-1:0]     index_in,
    output logic [NREQ-1:0]           gnt,
    output logic [IDX_W-1:0]          pal_index,
    input  logic [3:0]                pal_red,
    input  logic [3:0]                pal_green,
    input  logic [3:0]                pal_blue,
    output logic [11:0]               rgb_out,
    output logic                      rgb_valid,
    output logic [$clog2(NREQ)-1:0]   rgb_tag,
    output logic                      transparent
);

    localparam int unsigned TAG_W = $clog2(NREQ);

    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pal_index_q;
    logic             s1_valid_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [11:0]      rgb_out_q;
    logic             rgb_valid_q;
    logic [TAG_W-1:0] rgb_tag_q;
    logic             transparent_q;

    logic             found;
    logic [TAG_W-1:0] winner;
    logic [TAG_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] lookup_idx;

    // Scan upward from ptr_q modulo NREQ; first requesting slot wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = TAG_W'((32'(ptr_q) + off) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt[i] = found && !Reset && (32'(winner) == i);
        end
    end

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(winner) == i) begin
                win_idx = index_in[i*IDX_W +: IDX_W];
            end
        end
    end

`ifdef SPRITE_PAL_CLAMP_EN
    always_comb begin
        lookup_idx = win_idx;
        if (32'(win_idx) >= NUM_COLORS) begin
            lookup_idx = IDX_W'(CLAMP_INDEX);
        end
    end
`else
    assign lookup_idx = win_idx;
`endif

    // frame_start rewinds the pointer even when a grant is issued in the same cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            if (32'(winner) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + TAG_W'(1);
            end
        end
        if (frame_start) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q       <= '0;
            pal_index_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= found;
            if (found) begin
                pal_index_q <= lookup_idx;
                s1_tag_q    <= winner;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_out_q     <= '0;
            rgb_valid_q   <= 1'b0;
            rgb_tag_q     <= '0;
            transparent_q <= 1'b0;
        end else begin
            if (s1_valid_q) begin
                rgb_out_q <= {pal_red, pal_green, pal_blue};
            end
            rgb_tag_q     <= s1_tag_q;
            rgb_valid_q   <= s1_valid_q;
            transparent_q <= s1_valid_q && (pal_index_q == IDX_W'(TRANSPARENT_INDEX));
        end
    end

    assign pal_index   = pal_index_q;
    assign rgb_out     = rgb_out_q;
    assign rgb_valid   = rgb_valid_q;
    assign rgb_tag     = rgb_tag_q;
    assign transparent = transparent_q;

endmodule
